vx_lane_serializer: RTL and testbench

Splits one issued warp instruction, carrying `NUM_THREADS` lanes of operands, into a sequence of `NUM_LANES`-wide packets for a narrow execute unit. Packets whose thread-mask slice is empty are skipped. Each packet is tagged with packet id `pid`, start-of-packet `sop` and end-of-packet `eop`. The block sits directly upstream of the PE switch inside each functional unit, and its output is the execute stream that the switch routes to a PE.

---
 rtl/vx_lane_serializer.sv | 152 +++++++++++++++
 tb/tb_vx_lane_serializer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/vx_lane_serializer.sv
// Splits a NUM_THREADS-lane instruction into NUM_LANES-wide packets, skipping empty slices; latency 0 (OUT_BUF=0) or 1 cycle.
// Backpressure: the input is held in place until the eop packet is accepted; ready_out=0 freezes the output and pid_r.
module vx_lane_serializer #(
   parameter int NUM_THREADS = 4,
   parameter int NUM_LANES   = 4,
   parameter int XLEN        = 32,
   parameter int LANE_DW     = 3 * XLEN,
   parameter int HDR_W       = 64,
   parameter int OUT_BUF     = 1,
   parameter int PID_W       = ((NUM_THREADS / NUM_LANES) > 1) ? $clog2(NUM_THREADS / NUM_LANES) : 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           valid_in,
   output logic                           ready_in,
   input  logic [NUM_THREADS-1:0]         tmask_in,
   input  logic [HDR_W-1:0]               hdr_in,
   input  logic [NUM_THREADS*LANE_DW-1:0] data_in,
   output logic                           valid_out,
   input  logic                           ready_out,
   output logic [NUM_LANES-1:0]           tmask_out,
   output logic [HDR_W-1:0]               hdr_out,
   output logic [NUM_LANES*LANE_DW-1:0]   data_out,
   output logic [PID_W-1:0]               pid_out,
   output logic                           sop_out,
   output logic                           eop_out
);
   localparam int BATCH = NUM_THREADS / NUM_LANES;

   typedef struct packed {
      logic [PID_W-1:0]             pid;
      logic                         sop;
      logic                         eop;
      logic [NUM_LANES-1:0]         tmask;
      logic [HDR_W-1:0]             hdr;
      logic [NUM_LANES*LANE_DW-1:0] data;
   } pkt_t;

   logic [BATCH-1:0] act;
   logic [PID_W-1:0] pid_r;
   logic [PID_W-1:0] e_idx;
   logic             sop;
   logic             eop;
   logic             buf_ready;
   logic             fire;
   pkt_t             pkt_in;
   pkt_t             pkt_o;
   logic             vld_o;

   // A zero mask finds no active slice, leaving e=0 with sop=eop=1 so commit still sees one packet.
   always_comb begin
      act   = '0;
      e_idx = '0;
      sop   = 1'b1;
      eop   = 1'b1;
      for (int p = 0; p < BATCH; p++) begin
         act[p] = |tmask_in[p*NUM_LANES +: NUM_LANES];
      end
      for (int p = BATCH - 1; p >= 0; p--) begin
         if (act[p] && (p >= int'(pid_r))) begin
            e_idx = PID_W'(p);
         end
      end
      for (int p = 0; p < BATCH; p++) begin
         if (act[p] && (p < int'(e_idx))) sop = 1'b0;
         if (act[p] && (p > int'(e_idx))) eop = 1'b0;
      end
   end

   always_comb begin
      pkt_in       = '0;
      pkt_in.pid   = e_idx;
      pkt_in.sop   = sop;
      pkt_in.eop   = eop;
      pkt_in.tmask = tmask_in[int'(e_idx)*NUM_LANES +: NUM_LANES];
      pkt_in.hdr   = hdr_in;
      pkt_in.data  = data_in[int'(e_idx)*NUM_LANES*LANE_DW +: NUM_LANES*LANE_DW];
   end

   assign fire     = valid_in && buf_ready;
   assign ready_in = fire && eop;

   generate
      if (BATCH > 1) begin : g_pid
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               pid_r <= '0;
            end else if (fire) begin
               pid_r <= eop ? '0 : e_idx + PID_W'(1);
            end
         end
      end else begin : g_no_pid
         assign pid_r = '0;
      end
   endgenerate

   generate
      if (OUT_BUF == 0) begin : g_comb
         assign buf_ready = ready_out;
         assign vld_o     = valid_in;
         assign pkt_o     = pkt_in;
      end else if (OUT_BUF == 1) begin : g_pipe
         pkt_t pipe_q;
         logic pipe_vld;
         assign buf_ready = !pipe_vld || ready_out;
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               pipe_vld <= 1'b0;
               pipe_q   <= '0;
            end else if (buf_ready) begin
               pipe_vld <= valid_in;
               if (valid_in) pipe_q <= pkt_in;
            end
         end
         assign vld_o = pipe_vld;
         assign pkt_o = pipe_q;
      end else begin : g_skid
         pkt_t out_q;
         pkt_t skid_q;
         logic out_vld;
         logic skid_vld;
         // Ready depends only on skid occupancy, breaking the combinational ready path.
         assign buf_ready = !skid_vld;
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               out_vld  <= 1'b0;
               skid_vld <= 1'b0;
               out_q    <= '0;
               skid_q   <= '0;
            end else if (!out_vld || ready_out) begin
               if (skid_vld) begin
                  out_q    <= skid_q;
                  out_vld  <= 1'b1;
                  skid_vld <= 1'b0;
               end else begin
                  out_vld <= fire;
                  if (fire) out_q <= pkt_in;
               end
            end else if (fire) begin
               skid_vld <= 1'b1;
               skid_q   <= pkt_in;
            end
         end
         assign vld_o = out_vld;
         assign pkt_o = out_q;
      end
   endgenerate

   assign valid_out = vld_o;
   assign {pid_out, sop_out, eop_out, tmask_out, hdr_out, data_out} = pkt_o;

endmodule

// File: tb/tb_vx_lane_serializer.sv
// Scoreboard bench for vx_lane_serializer (8 threads, 2 lanes, skid output buffer).
module tb_vx_lane_serializer;
   localparam int NT    = 8;
   localparam int NL    = 2;
   localparam int LDW   = 8;
   localparam int HW    = 16;
   localparam int OB    = 2;
   localparam int BATCH = NT / NL;
   localparam int PW    = 2;

   typedef struct packed {
      logic [PW-1:0]     pid;
      logic              sop;
      logic              eop;
      logic [NL-1:0]     tmask;
      logic [HW-1:0]     hdr;
      logic [NL*LDW-1:0] data;
   } pkt_t;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              valid_in = 1'b0;
   logic              ready_in;
   logic [NT-1:0]     tmask_in = '0;
   logic [HW-1:0]     hdr_in = '0;
   logic [NT*LDW-1:0] data_in = '0;
   logic              valid_out;
   logic              ready_out = 1'b1;
   logic [NL-1:0]     tmask_out;
   logic [HW-1:0]     hdr_out;
   logic [NL*LDW-1:0] data_out;
   logic [PW-1:0]     pid_out;
   logic              sop_out;
   logic              eop_out;

   int   n_checks = 0;
   int   n_fail = 0;
   int   mode = 0;
   pkt_t exp_q[$];

   vx_lane_serializer #(
      .NUM_THREADS(NT), .NUM_LANES(NL), .LANE_DW(LDW), .HDR_W(HW), .OUT_BUF(OB), .PID_W(PW)
   ) dut (
      .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
      .tmask_in(tmask_in), .hdr_in(hdr_in), .data_in(data_in),
      .valid_out(valid_out), .ready_out(ready_out), .tmask_out(tmask_out),
      .hdr_out(hdr_out), .data_out(data_out), .pid_out(pid_out),
      .sop_out(sop_out), .eop_out(eop_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: list the non-empty slices in order; first is sop, last is eop.
   function automatic int model(input logic [NT-1:0] tm, input logic [HW-1:0] h,
                                input logic [NT*LDW-1:0] d, input int limit);
      int idx[$];
      for (int p = 0; p < BATCH; p++)
         if (tm[p*NL +: NL] != '0) idx.push_back(p);
      if (idx.size() == 0) idx.push_back(0);
      for (int i = 0; i < idx.size(); i++) begin
         pkt_t x;
         x.pid   = PW'(idx[i]);
         x.sop   = (i == 0);
         x.eop   = (i == idx.size() - 1);
         x.tmask = tm[idx[i]*NL +: NL];
         x.hdr   = h;
         x.data  = d[idx[i]*NL*LDW +: NL*LDW];
         if (i < limit) exp_q.push_back(x);
      end
      return idx.size();
   endfunction

   function automatic logic [NT-1:0] rand_tm();
      logic [NT-1:0] t;
      int p;
      t = '0;
      case ($urandom_range(0, 3))
         0: t = '0;
         1: begin
            p = $urandom_range(0, BATCH - 1);
            t[p*NL +: NL] = NL'($urandom_range(1, 3));
         end
         default: t = NT'($urandom);
      endcase
      return t;
   endfunction

   task automatic send(input logic [NT-1:0] tm, input bit occ, input bit lat);
      int k;
      int cyc;
      tmask_in = tm;
      hdr_in   = HW'($urandom);
      data_in  = {$urandom, $urandom};
      k        = model(tm, hdr_in, data_in, BATCH);
      valid_in = 1'b1;
      cyc      = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (lat && cyc <= 2) chk("first_packet_latency", 64'(valid_out), 64'(cyc == 2));
         if (ready_in) break;
         if (cyc >= 300) begin
            chk("ready_in_timeout", 64'(ready_in), 64'(1));
            break;
         end
      end
      if (occ) chk("input_occupancy_cycles", 64'(cyc), 64'(k));
      @(posedge clk);
      #1;
      valid_in = 1'b0;
   endtask

   initial begin : ready_gen
      int ph;
      ph = 0;
      forever begin
         @(posedge clk);
         #1;
         case (mode)
            0: ready_out = 1'b1;
            1: ready_out = 1'($urandom_range(0, 1));
            default: begin
               ready_out = (ph % 3 == 0);
               ph++;
            end
         endcase
      end
   end

   initial begin : monitor
      pkt_t cur;
      pkt_t prev;
      bit   stall;
      stall = 1'b0;
      prev  = '0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            stall = 1'b0;
         end else begin
            cur = {pid_out, sop_out, eop_out, tmask_out, hdr_out, data_out};
            if (!valid_in) chk("ready_in_while_idle", 64'(ready_in), 64'(0));
            if (stall) begin
               chk("stall_valid_held", 64'(valid_out), 64'(1));
               chk("stall_payload_held", 64'(cur), 64'(prev));
            end
            stall = valid_out && !ready_out;
            prev  = cur;
            if (valid_out && ready_out) begin
               if (exp_q.size() == 0) chk("unexpected_packet", 64'(valid_out), 64'(0));
               else chk("packet", 64'(cur), 64'(exp_q.pop_front()));
            end
         end
      end
   end

   initial begin : main
      #2;
      chk("reset_valid_out", 64'(valid_out), 64'(0));
      chk("reset_ready_in", 64'(ready_in), 64'(0));
      chk("reset_pid_out", 64'(pid_out), 64'(0));
      chk("reset_sop_out", 64'(sop_out), 64'(0));
      chk("reset_eop_out", 64'(eop_out), 64'(0));
      chk("reset_tmask_out", 64'(tmask_out), 64'(0));
      #20;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;

      mode = 0;
      send(8'hFF, 1'b1, 1'b1);
      send(8'h30, 1'b1, 1'b0);
      send(8'h81, 1'b1, 1'b0);
      send(8'h00, 1'b1, 1'b0);

      mode = 2;
      repeat (2) send(8'hFF, 1'b0, 1'b0);

      mode = 1;
      repeat (40) send(rand_tm(), 1'b0, 1'b0);

      mode = 0;
      repeat (6) @(posedge clk);
      #1;
      repeat (20) send(rand_tm(), 1'b1, 1'b0);

      // Reset after pid1 enters the buffer: only pid0 reaches the output.
      repeat (4) @(posedge clk);
      #1;
      tmask_in = 8'hFF;
      hdr_in   = HW'($urandom);
      data_in  = {$urandom, $urandom};
      void'(model(tmask_in, hdr_in, data_in, 1));
      valid_in = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset    = 1'b0;
      valid_in = 1'b0;
      #1;
      chk("midreset_valid_out", 64'(valid_out), 64'(0));
      chk("midreset_pid_out", 64'(pid_out), 64'(0));
      chk("midreset_sop_out", 64'(sop_out), 64'(0));
      chk("midreset_tmask_out", 64'(tmask_out), 64'(0));
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      send(8'hFF, 1'b1, 1'b1);

      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
